// File: rtl/row_sr_ctrl_pkg.sv
// Shared types and constant helpers for the row shift-register sequencer.
package row_sr_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Last legal window column (window left edge).
    function automatic int last_col_pos(input int img_w, input int win);
        return img_w - win;
    endfunction

    // Last legal window row (window top edge).
    function automatic int last_row_pos(input int img_h, input int win);
        return img_h - win;
    endfunction

    // Pixels per frame, computed wide so the range check cannot overflow.
    function automatic longint frame_pixels(input int img_w, input int img_h);
        return longint'(img_w) * longint'(img_h);
    endfunction

endpackage

// File: rtl/row_sr_ctrl_if.sv
// Pixel, row-SR and window handshake bundle between the sequencer and its neighbours.
interface row_sr_ctrl_if
    import row_sr_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic             pix_valid;
    logic             pix_ready;
    logic             sr_full;
    logic             sr_row_shift_rdy;
    logic             sr_shift_in_enable;
    logic             sr_shift_out_enable;
    logic             sr_shift_row_up;
    logic             win_valid;
    logic             win_ready;
    logic [CNT_W-1:0] win_col;
    logic [CNT_W-1:0] win_row;

    // Sequencer side: drives strobes, ready and window position.
    modport master (
        input  pix_valid,
        input  sr_full,
        input  sr_row_shift_rdy,
        input  win_ready,
        output pix_ready,
        output sr_shift_in_enable,
        output sr_shift_out_enable,
        output sr_shift_row_up,
        output win_valid,
        output win_col,
        output win_row
    );

    // Environment side: upstream pixel source, row SR and window datapath.
    modport slave (
        output pix_valid,
        output sr_full,
        output sr_row_shift_rdy,
        output win_ready,
        input  pix_ready,
        input  sr_shift_in_enable,
        input  sr_shift_out_enable,
        input  sr_shift_row_up,
        input  win_valid,
        input  win_col,
        input  win_row
    );

endinterface

// File: rtl/row_sr_ctrl_win_pos_counter.sv
// Column/row position counter for the window left-top corner; the column
// wraps at the last window column and the row wraps after the last window.
module win_pos_counter
    import row_sr_ctrl_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int LAST_COL = 5,
    parameter int LAST_ROW = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             last_col,
    output logic             last_win
);

    localparam logic [CNT_W-1:0] COL_END = CNT_W'(LAST_COL);
    localparam logic [CNT_W-1:0] ROW_END = CNT_W'(LAST_ROW);

    assign last_col = (col == COL_END);
    assign last_win = last_col && (row == ROW_END);

    // Advance position on each consumed window; clear wins over advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (last_col) begin
                col <= '0;
                row <= last_win ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/row_sr_ctrl.sv
// Sequencer for the row shift register feeding the first row of the
// convolution window: gates pixels in, shifts one column per window and
// skips to the next row at the end of each output row.
module row_sr_ctrl
    import row_sr_ctrl_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 4,
    parameter int WIN   = 3,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    row_sr_ctrl_if.master bus,
    output logic          frame_done
);

    localparam int               LAST_COL    = last_col_pos(IMG_W, WIN);
    localparam int               LAST_ROW    = last_row_pos(IMG_H, WIN);
    localparam longint           FRAME_PIX_L = frame_pixels(IMG_W, IMG_H);
    localparam logic [CNT_W-1:0] FRAME_PIX   = CNT_W'(FRAME_PIX_L);

    // Pixel count must fit the counters, and the window must fit the image.
    if (FRAME_PIX_L >= (longint'(1) << CNT_W)) begin : g_size_check
        $error("row_sr_ctrl: IMG_W*IMG_H does not fit in CNT_W bits");
    end
    if ((WIN < 1) || (WIN > IMG_W) || (WIN > IMG_H)) begin : g_win_check
        $error("row_sr_ctrl: WIN must be in 1..min(IMG_W, IMG_H)");
    end

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] win_col;
    logic [CNT_W-1:0] win_row;
    logic             pix_ready;
    logic             win_valid;
    logic             accept;
    logic             consume;
    logic             row_up;
    logic             last_col;
    logic             last_win;
    logic             frame_start;
    logic             pos_clr;

    // A new frame only starts from IDLE, and abort beats start.
    assign frame_start = (state == IDLE) && start && !abort;
    assign pos_clr     = frame_start || abort;

    // Handshake and row-SR strobe decode; every output is zero in IDLE.
    always_comb begin
        pix_ready = 1'b0;
        win_valid = 1'b0;
        accept    = 1'b0;
        consume   = 1'b0;
        row_up    = 1'b0;
        if (((state == FILL) || (state == SHIFT)) && !bus.sr_full &&
            (pix_cnt < FRAME_PIX)) begin
            pix_ready = 1'b1;
        end
        win_valid = (state == SHIFT) && bus.sr_row_shift_rdy;
        accept    = bus.pix_valid && pix_ready;
        consume   = win_valid && bus.win_ready;
        row_up    = consume && last_col;
    end

    assign bus.pix_ready           = pix_ready;
    assign bus.sr_shift_in_enable  = accept;
    assign bus.sr_shift_out_enable = consume;
    assign bus.sr_shift_row_up     = row_up;
    assign bus.win_valid           = win_valid;
    assign bus.win_col             = win_col;
    assign bus.win_row             = win_row;
    assign frame_done              = (state == DONE);

    // Frame state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort returns to IDLE from anywhere without DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FILL;
            FILL:    if (bus.sr_row_shift_rdy) state_next = SHIFT;
            SHIFT:   if (consume && last_win) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    // Count accepted pixels so intake stops once the whole frame is in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pix_cnt <= '0;
        end else if (pos_clr) begin
            pix_cnt <= '0;
        end else if (accept) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
        end
    end

    win_pos_counter #(
        .CNT_W    (CNT_W),
        .LAST_COL (LAST_COL),
        .LAST_ROW (LAST_ROW)
    ) u_win_pos (
        .clock    (clock),
        .reset    (reset),
        .inc      (consume),
        .clr      (pos_clr),
        .col      (win_col),
        .row      (win_row),
        .last_col (last_col),
        .last_win (last_win)
    );

endmodule

// File: tb/tb_row_sr_ctrl.sv
// Directed bench for row_sr_ctrl with a small row-SR occupancy model that
// asserts row_shift_rdy once the pixels for the next window have arrived.
module tb_row_sr_ctrl;
    import row_sr_ctrl_pkg::*;

    localparam int IMG_W = 8;
    localparam int IMG_H = 4;
    localparam int WIN   = 3;
    localparam int CNT_W = 16;
    localparam int CAP   = 24;
    localparam int LASTC = IMG_W - WIN;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic frame_done;
    logic force_full = 1'b0;
    logic sr_clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Environment model state
    int wr_cnt, mc, mr;
    int cnt_in, cnt_out, cnt_up, cnt_done;
    int up_col[4];
    int up_row[4];

    row_sr_ctrl_if #(.CNT_W(CNT_W)) bus();

    row_sr_ctrl #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .WIN   (WIN),
        .CNT_W (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .bus        (bus.master),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    assign bus.sr_full          = force_full || ((wr_cnt - (mr * IMG_W + mc)) >= CAP);
    assign bus.sr_row_shift_rdy = (wr_cnt >= ((mr + WIN - 1) * IMG_W + mc + WIN));

    always @(posedge clock or negedge reset) begin
        if (!reset || sr_clr) begin
            wr_cnt <= 0; mc <= 0; mr <= 0;
            cnt_in <= 0; cnt_out <= 0; cnt_up <= 0; cnt_done <= 0;
        end else begin
            if (bus.sr_shift_in_enable) begin
                wr_cnt <= wr_cnt + 1;
                cnt_in <= cnt_in + 1;
            end
            if (bus.sr_shift_out_enable) begin
                cnt_out <= cnt_out + 1;
                if (mc == LASTC) begin
                    mc <= 0;
                    mr <= mr + 1;
                end else begin
                    mc <= mc + 1;
                end
            end
            if (bus.sr_shift_row_up) begin
                if (cnt_up < 4) begin
                    up_col[cnt_up] <= int'(bus.win_col);
                    up_row[cnt_up] <= int'(bus.win_row);
                end
                cnt_up <= cnt_up + 1;
            end
            if (frame_done) cnt_done <= cnt_done + 1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_env();
        start = 1'b0; force_full = 1'b0; bus.pix_valid = 1'b0; bus.win_ready = 1'b0;
        abort = 1'b1; sr_clr = 1'b1;
        tick();
        abort = 1'b0; sr_clr = 1'b0;
    endtask

    task automatic start_frame();
        bus.pix_valid = 1'b1; bus.win_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.pix_valid = 1'b1; bus.win_ready = 1'b1;
        #12;
        n_vec++; if (bus.pix_ready !== 1'b0) begin n_err++; $display("FAIL rst_pix_ready got %b want 0", bus.pix_ready); end
        n_vec++; if (bus.win_valid !== 1'b0) begin n_err++; $display("FAIL rst_win_valid got %b want 0", bus.win_valid); end
        n_vec++; if (bus.sr_shift_in_enable !== 1'b0) begin n_err++; $display("FAIL rst_in_en got %b want 0", bus.sr_shift_in_enable); end
        n_vec++; if (bus.sr_shift_out_enable !== 1'b0) begin n_err++; $display("FAIL rst_out_en got %b want 0", bus.sr_shift_out_enable); end
        n_vec++; if (bus.sr_shift_row_up !== 1'b0) begin n_err++; $display("FAIL rst_row_up got %b want 0", bus.sr_shift_row_up); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
        n_vec++; if (bus.win_col !== 16'd0) begin n_err++; $display("FAIL rst_win_col got %0d want 0", bus.win_col); end
        n_vec++; if (bus.win_row !== 16'd0) begin n_err++; $display("FAIL rst_win_row got %0d want 0", bus.win_row); end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) tick();
        n_vec++; if (dut.state !== IDLE) begin n_err++; $display("FAIL rst_idle_hold state got %0d want %0d", dut.state, IDLE); end
        n_vec++; if (bus.pix_ready !== 1'b0) begin n_err++; $display("FAIL rst_idle_pix_ready got %b want 0", bus.pix_ready); end
    endtask

    task automatic test_basic_frame();
        bit done_seen = 1'b0;
        int post = 0;
        clear_env();
        start_frame();
        for (int i = 0; i < 200 && post < 3; i++) begin
            @(negedge clock);
            if (bus.win_valid && bus.win_ready) begin
                n_vec++; if (int'(bus.win_col) !== mc || int'(bus.win_row) !== mr) begin
                    n_err++; $display("FAIL basic_pos got (%0d,%0d) want (%0d,%0d)", bus.win_col, bus.win_row, mc, mr);
                end
            end
            if (frame_done) done_seen = 1'b1;
            if (done_seen) post++;
        end
        n_vec++; if (!done_seen) begin n_err++; $display("FAIL basic_timeout frame_done got 0 want 1"); end
        n_vec++; if (cnt_in !== 32) begin n_err++; $display("FAIL basic_accepts got %0d want 32", cnt_in); end
        n_vec++; if (cnt_out !== 12) begin n_err++; $display("FAIL basic_consumes got %0d want 12", cnt_out); end
        n_vec++; if (cnt_up !== 2) begin n_err++; $display("FAIL basic_row_ups got %0d want 2", cnt_up); end
        n_vec++; if (up_col[0] !== 5 || up_row[0] !== 0) begin n_err++; $display("FAIL basic_row_up0 got (%0d,%0d) want (5,0)", up_col[0], up_row[0]); end
        n_vec++; if (up_col[1] !== 5 || up_row[1] !== 1) begin n_err++; $display("FAIL basic_row_up1 got (%0d,%0d) want (5,1)", up_col[1], up_row[1]); end
        n_vec++; if (cnt_done !== 1) begin n_err++; $display("FAIL basic_done_pulses got %0d want 1", cnt_done); end
        n_vec++; if (dut.state !== IDLE) begin n_err++; $display("FAIL basic_end_state got %0d want %0d", dut.state, IDLE); end
        n_vec++; if (bus.pix_ready !== 1'b0) begin n_err++; $display("FAIL basic_end_pix_ready got %b want 0", bus.pix_ready); end
    endtask

    task automatic test_backpressure();
        bit found = 1'b0;
        clear_env();
        start_frame();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.win_col == 16'd2 && bus.win_row == 16'd0) begin found = 1'b1; break; end
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL bp_reach_timeout got 0 want 1"); end
        else begin
            bus.win_ready = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clock);
                n_vec++; if (bus.win_col !== 16'd2) begin n_err++; $display("FAIL bp_hold_col got %0d want 2", bus.win_col); end
                n_vec++; if (bus.sr_shift_out_enable !== 1'b0) begin n_err++; $display("FAIL bp_out_en got %b want 0", bus.sr_shift_out_enable); end
            end
            n_vec++; if (cnt_in !== 26) begin n_err++; $display("FAIL bp_accepts got %0d want 26", cnt_in); end
            n_vec++; if (dut.pix_cnt !== 16'd26) begin n_err++; $display("FAIL bp_pix_cnt got %0d want 26", dut.pix_cnt); end
            n_vec++; if (bus.pix_ready !== 1'b0) begin n_err++; $display("FAIL bp_pix_ready got %b want 0", bus.pix_ready); end
            bus.win_ready = 1'b1;
            #1;
            n_vec++; if (bus.sr_shift_out_enable !== 1'b1) begin n_err++; $display("FAIL bp_release_out_en got %b want 1", bus.sr_shift_out_enable); end
            @(negedge clock);
            n_vec++; if (bus.win_col !== 16'd3 || bus.win_row !== 16'd0) begin n_err++; $display("FAIL bp_resume got (%0d,%0d) want (3,0)", bus.win_col, bus.win_row); end
        end
    endtask

    task automatic test_full_gating();
        int snap;
        clear_env();
        start_frame();
        repeat (3) tick();
        force_full = 1'b1;
        snap = cnt_in;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_vec++; if (bus.pix_ready !== 1'b0) begin n_err++; $display("FAIL full_pix_ready got %b want 0", bus.pix_ready); end
            n_vec++; if (bus.sr_shift_in_enable !== 1'b0) begin n_err++; $display("FAIL full_in_en got %b want 0", bus.sr_shift_in_enable); end
        end
        tick();
        n_vec++; if (int'(dut.pix_cnt) !== snap) begin n_err++; $display("FAIL full_pix_cnt got %0d want %0d", dut.pix_cnt, snap); end
        force_full = 1'b0;
        #1;
        n_vec++; if (bus.pix_ready !== 1'b1) begin n_err++; $display("FAIL full_release_pix_ready got %b want 1", bus.pix_ready); end
    endtask

    task automatic test_simultaneous();
        bit found = 1'b0;
        int pc, c;
        clear_env();
        start_frame();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.pix_valid && bus.pix_ready && bus.win_valid && bus.win_ready && mc < LASTC) begin
                found = 1'b1; break;
            end
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL sim_timeout got 0 want 1"); end
        else begin
            n_vec++; if (bus.sr_shift_in_enable !== 1'b1 || bus.sr_shift_out_enable !== 1'b1) begin
                n_err++; $display("FAIL sim_strobes got in=%b out=%b want 1 1", bus.sr_shift_in_enable, bus.sr_shift_out_enable);
            end
            pc = cnt_in; c = mc;
            tick();
            n_vec++; if (int'(dut.pix_cnt) !== pc + 1) begin n_err++; $display("FAIL sim_pix_cnt got %0d want %0d", dut.pix_cnt, pc + 1); end
            n_vec++; if (int'(bus.win_col) !== c + 1) begin n_err++; $display("FAIL sim_win_col got %0d want %0d", bus.win_col, c + 1); end
        end
    endtask

    task automatic test_abort_start();
        bit found = 1'b0;
        int snap;
        clear_env();
        start_frame();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.win_valid) begin found = 1'b1; break; end
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL abort_shift_timeout got 0 want 1"); end
        else begin
            start = 1'b1;
            tick();
            start = 1'b0;
            n_vec++; if (dut.state !== SHIFT) begin n_err++; $display("FAIL start_in_shift_state got %0d want %0d", dut.state, SHIFT); end
            n_vec++; if (bus.win_col !== 16'd1) begin n_err++; $display("FAIL start_in_shift_col got %0d want 1", bus.win_col); end
            n_vec++; if (int'(dut.pix_cnt) !== cnt_in) begin n_err++; $display("FAIL start_in_shift_pix_cnt got %0d want %0d", dut.pix_cnt, cnt_in); end
        end
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.win_col == 16'd4 && bus.win_row == 16'd1) begin found = 1'b1; break; end
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL abort_reach_timeout got 0 want 1"); end
        else begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            n_vec++; if (dut.state !== IDLE) begin n_err++; $display("FAIL abort_state got %0d want %0d", dut.state, IDLE); end
            n_vec++; if (bus.win_col !== 16'd0 || bus.win_row !== 16'd0) begin n_err++; $display("FAIL abort_pos got (%0d,%0d) want (0,0)", bus.win_col, bus.win_row); end
            n_vec++; if (bus.pix_ready !== 1'b0) begin n_err++; $display("FAIL abort_pix_ready got %b want 0", bus.pix_ready); end
            n_vec++; if (dut.pix_cnt !== 16'd0) begin n_err++; $display("FAIL abort_pix_cnt got %0d want 0", dut.pix_cnt); end
            snap = cnt_done;
            repeat (5) tick();
            n_vec++; if (cnt_done !== snap) begin n_err++; $display("FAIL abort_done_pulse got %0d want %0d", cnt_done, snap); end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        clear_env();
        start_frame();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.win_col == 16'd1 && bus.win_row == 16'd0) begin found = 1'b1; break; end
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL rmid_reach_timeout got 0 want 1"); end
        else begin
            reset = 1'b0;
            #1;
            n_vec++; if (bus.win_valid !== 1'b0 || bus.pix_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready_valid got %b %b want 0 0", bus.win_valid, bus.pix_ready); end
            n_vec++; if (bus.sr_shift_in_enable !== 1'b0 || bus.sr_shift_out_enable !== 1'b0 || bus.sr_shift_row_up !== 1'b0) begin
                n_err++; $display("FAIL rmid_strobes got %b%b%b want 000", bus.sr_shift_in_enable, bus.sr_shift_out_enable, bus.sr_shift_row_up);
            end
            n_vec++; if (bus.win_col !== 16'd0 || bus.win_row !== 16'd0) begin n_err++; $display("FAIL rmid_pos got (%0d,%0d) want (0,0)", bus.win_col, bus.win_row); end
            n_vec++; if (dut.state !== IDLE) begin n_err++; $display("FAIL rmid_state got %0d want %0d", dut.state, IDLE); end
            @(posedge clock);
            #2;
            reset = 1'b1;
            repeat (5) tick();
            n_vec++; if (dut.state !== IDLE) begin n_err++; $display("FAIL rmid_stay_idle got %0d want %0d", dut.state, IDLE); end
            n_vec++; if (bus.pix_ready !== 1'b0) begin n_err++; $display("FAIL rmid_pix_ready got %b want 0", bus.pix_ready); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pix_valid = 1'b0;
        bus.win_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_full_gating();
        test_simultaneous();
        test_abort_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
